tilemap_edit_writer: RTL
========================

// Module: tilemap_edit_writer
// PURPOSE
//  Write-side port of the tilemap RAM, the counterpart to the background-collision reader.
//  It accepts tile edit requests (x, y, tile) through a valid/ready handshake and buffers them in a small FIFO.
//  Each edit is written to the RAM, then read back and checked.
//  A clear command fills the whole map with one tile value.
//  It sits between game logic (block breaking, level load) and the single-port tilemap RAM.
// PARAMETERS
//  TILEMAP_LENGTH  100  tiles per row; row stride for address calc
//  TILEMAP_HEIGHT  15   rows in map
//  X_WIDTH         7    width of req_x
//  FIFO_DEPTH      4    request buffer entries (power of 2)
// PORTS
//  clock         in   1   system clock, rising edge
//  resetn        in   1   asynchronous, active-low reset
//  req_valid     in   1   edit request present
//  req_ready     out  1   request accepted on valid&&ready
//  req_x         in   7   tile column
//  req_y         in   4   tile row
//  req_tile      in   3   tile code to write (0 = empty)
//  clear_start   in   1   request full-map fill; sampled only in IDLE
//  clear_tile    in   3   fill value, latched with clear_start
//  mem_address   out  15  tilemap RAM address
//  mem_data_out  out  3   RAM write data
//  mem_wren      out  1   RAM write enable
//  mem_data_in   in   3   RAM read data, valid 1 cycle after address
//  busy          out  1   FSM not in IDLE, or FIFO non-empty
//  done          out  1   1-cycle pulse: edit verified / clear finished
//  error         out  1   sticky: readback mismatch or out-of-range request
//  error_clear   in   1   clears error; a same-cycle new error wins
// BEHAVIOUR
//  Reset: FIFO emptied; FSM=IDLE; req_ready=0 during reset.
//   mem_wren, done, error, mem_address and mem_data_out are all 0. Any in-flight write is aborted.
//  req_ready = !fifo_full && state not in {CLEAR}; combinational from registered state.
//  FIFO: push on valid&&ready; pop on POP entry. Simultaneous push+pop leaves count unchanged.
//   Order is FIFO; a full FIFO never overwrites.
//  States: IDLE, POP, WRITE, READBACK, CHECK, CLEAR.
//   IDLE:     if clear_start -> CLEAR (clear has priority over pending entries; addr ctr=0).
//             elif FIFO non-empty -> POP. else stay.
//   POP:      latch head entry.
//             addr = x + y*TILEMAP_LENGTH, computed at 15 bits (max 1499, no truncation).
//             If x>=TILEMAP_LENGTH or y>=TILEMAP_HEIGHT: error<=1, no write, no done, -> IDLE.
//             Otherwise -> WRITE.
//   WRITE:    mem_address=addr, mem_data_out=tile, mem_wren=1 for exactly 1 cycle; -> READBACK.
//   READBACK: mem_address=addr, mem_wren=0; -> CHECK.
//   CHECK:    compare mem_data_in to tile. Mismatch -> error<=1.
//             done=1 this cycle either way. -> POP if FIFO non-empty, else IDLE.
//   CLEAR:    mem_wren=1, mem_address=ctr, mem_data_out=clear_tile, ctr++ each cycle.
//             At ctr==TILEMAP_LENGTH*TILEMAP_HEIGHT-1: done=1 that cycle, -> IDLE.
//             Total 1500 write cycles; no readback during clear.
//  Outside WRITE/READBACK/CLEAR: mem_address=0, mem_wren=0, mem_data_out=0.
//  Latency: accept at edge N into an empty FIFO with FSM in IDLE.
//   POP at N+1, WRITE at N+2, READBACK at N+3, done at N+4. Back-to-back edits cost 4 cycles each.
//  clear_start outside IDLE is ignored (not queued).
//  Requests arriving during CLEAR stall on req_ready=0.
//  Reset asserted mid-WRITE or mid-CLEAR: mem_wren drops immediately (async); the map is left partially updated.
// TESTING
//  1) Reset, push (x=5,y=2,tile=3), RAM model ok -> mem_wren=1 once at addr 205 data 3; done pulse 4 cycles after accept; error=0.
//  2) Push 5 requests back-to-back with no stall from FSM -> req_ready low after 4 buffered.
//     All 5 written in order at their addresses; 5 done pulses, 4 cycles apart.
//  3) Push (x=100,y=0) and then (x=0,y=15) -> no write for either, error=1, no done.
//     error_clear pulse -> error=0. Error event together with error_clear -> error stays 1.
//  4) RAM model corrupts readback (returns 0 for tile 5) -> done pulses, error=1.
//  5) clear_start with clear_tile=0 in IDLE and 2 queued edits -> 1500 writes to addr 0..1499, done at addr 1499.
//     Queued edits are written afterwards. req_ready=0 throughout clear.
//  6) Assert resetn low during CLEAR at addr 700 -> mem_wren=0 immediately; after release FSM=IDLE, FIFO empty, busy=0.

Source files
------------

// File: rtl/tilemap_edit_writer.sv
// Write-side port of the tilemap RAM: queues tile edits, writes each one, reads it back to verify,
// and can flood-fill the whole map with a single tile value.
module tilemap_edit_writer #(
   parameter int unsigned TILEMAP_LENGTH = 100,
   parameter int unsigned TILEMAP_HEIGHT = 15,
   parameter int unsigned X_WIDTH        = 7,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [X_WIDTH-1:0] req_x,
   input  logic [3:0]         req_y,
   input  logic [2:0]         req_tile,
   input  logic               clear_start,
   input  logic [2:0]         clear_tile,
   output logic [14:0]        mem_address,
   output logic [2:0]         mem_data_out,
   output logic               mem_wren,
   input  logic [2:0]         mem_data_in,
   output logic               busy,
   output logic               done,
   output logic               error,
   input  logic               error_clear
);

   localparam int unsigned MAP_SIZE  = TILEMAP_LENGTH * TILEMAP_HEIGHT;
   localparam int unsigned CTR_WIDTH = $clog2(MAP_SIZE);
   localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);

   localparam logic [CTR_WIDTH-1:0] LAST_ADDR       = CTR_WIDTH'(MAP_SIZE - 1);
   localparam logic [14:0]          ROW_STRIDE      = 15'(TILEMAP_LENGTH);
   localparam logic [PTR_WIDTH:0]   FIFO_FULL_COUNT = (PTR_WIDTH + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_WRITE,
      S_READBACK,
      S_CHECK,
      S_CLEAR
   } state_t;

   typedef struct packed {
      logic [X_WIDTH-1:0] x;
      logic [3:0]         y;
      logic [2:0]         tile;
   } edit_t;

   state_t state, next_state;

   edit_t                fifo_mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [PTR_WIDTH:0]   fifo_count;
   logic                 fifo_full, fifo_empty;
   logic                 push, pop;
   logic                 ready_en;

   edit_t                cur;
   logic [14:0]          edit_addr;
   logic                 out_of_range;
   logic                 err_set;

   logic [CTR_WIDTH-1:0] clear_ctr;
   logic [2:0]           clear_val;

   assign fifo_full  = (fifo_count == FIFO_FULL_COUNT);
   assign fifo_empty = (fifo_count == '0);
   assign req_ready  = ready_en && !fifo_full && (state != S_CLEAR);
   assign push       = req_valid && req_ready;
   // Every transition into POP consumes one queued entry.
   assign pop        = (next_state == S_POP);
   assign busy       = (state != S_IDLE) || !fifo_empty;

   assign out_of_range = (32'(cur.x) >= TILEMAP_LENGTH) || (32'(cur.y) >= TILEMAP_HEIGHT);
   assign err_set      = ((state == S_POP) && out_of_range) ||
                         ((state == S_CHECK) && (mem_data_in != cur.tile));

   // Holds req_ready low while reset is asserted and for the first edge after release.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) ready_en <= 1'b0;
      else         ready_en <= 1'b1;
   end

   // NOTE: FIFO storage has no reset; entries are only ever read after being written,
   // and leaving the array unreset lets it map onto plain RAM or register files.
   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= '{x: req_x, y: req_y, tile: req_tile};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of block ordering.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cur       <= '0;
         edit_addr <= '0;
      end else begin
         if (pop) cur <= fifo_mem[rd_ptr];
         if (state == S_POP) edit_addr <= 15'(cur.x) + 15'(cur.y) * ROW_STRIDE;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         clear_ctr <= '0;
         clear_val <= '0;
      end else if ((state == S_IDLE) && clear_start) begin
         clear_ctr <= '0;
         clear_val <= clear_tile;
      end else if (state == S_CLEAR) begin
         clear_ctr <= clear_ctr + 1'b1;
      end
   end

   // A new error in the same cycle as error_clear keeps the flag set.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)          error <= 1'b0;
      else if (err_set)     error <= 1'b1;
      else if (error_clear) error <= 1'b0;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= next_state;
   end

   // NOTE: every combinational output gets a default before the case so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE: begin
            if (clear_start)      next_state = S_CLEAR;
            else if (!fifo_empty) next_state = S_POP;
         end
         S_POP:      next_state = out_of_range ? S_IDLE : S_WRITE;
         S_WRITE:    next_state = S_READBACK;
         S_READBACK: next_state = S_CHECK;
         S_CHECK:    next_state = fifo_empty ? S_IDLE : S_POP;
         S_CLEAR: begin
            if (clear_ctr == LAST_ADDR) next_state = S_IDLE;
         end
         default:    next_state = S_IDLE;
      endcase
   end

   always_comb begin
      mem_address  = '0;
      mem_data_out = '0;
      mem_wren     = 1'b0;
      done         = 1'b0;
      case (state)
         S_WRITE: begin
            mem_address  = edit_addr;
            mem_data_out = cur.tile;
            mem_wren     = 1'b1;
         end
         S_READBACK: mem_address = edit_addr;
         S_CHECK:    done = 1'b1;
         S_CLEAR: begin
            mem_address  = 15'(clear_ctr);
            mem_data_out = clear_val;
            mem_wren     = 1'b1;
            done         = (clear_ctr == LAST_ADDR);
         end
         default: ;
      endcase
   end

endmodule
